// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encoding and frame-format byte counts
package imem_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE} state_t;
  localparam int HDR_BYTES = 2;
  localparam int TRL_BYTES = 1;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: MSB-first byte-to-word shifter, pulses o_word_valid with the 4th byte
module imem_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  logic [23:0] r_sr;
  logic [1:0]  r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_sr  <= {r_sr[15:0], i_byte};
      r_cnt <= r_cnt + 2'd1;
    end
  end
  assign o_word       = {r_sr, i_byte};
  assign o_word_valid = i_en && (r_cnt == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a counted, XOR-checksummed byte frame and writes it into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_ovf,
  output logic              err_csum
);
  localparam int DEPTH = 2**ADDR_W;
  state_t            r_state, w_next;
  logic [7:0]        r_cnt_hi, r_csum;
  logic [CNT_W-1:0]  r_n, r_idx, w_n_rx;
  logic              r_we, r_ovf, r_ecsum;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, w_word;
  logic              w_xfer, w_start, w_wv, w_last, w_in_range;
  assign w_xfer     = in_valid && in_ready;
  assign w_start    = load_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_n_rx     = CNT_W'({r_cnt_hi, in_data});
  assign w_last     = r_idx == r_n - CNT_W'(1);
  assign w_in_range = 32'(r_idx) < DEPTH;
  imem_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start),
    .i_en         (w_xfer && r_state == S_DATA),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_wv)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next   = r_state;
    in_ready = r_state inside {S_HDR0, S_HDR1, S_DATA, S_CSUM};
    cpu_hold = in_ready;
    done     = r_state == S_DONE;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = S_HDR0;
      S_HDR0:         if (w_xfer) w_next = S_HDR1;
      S_HDR1:         if (w_xfer) w_next = (w_n_rx == '0) ? S_CSUM : S_DATA;
      S_DATA:         if (w_wv && w_last) w_next = S_CSUM;
      S_CSUM:         if (w_xfer) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end
  // words past DEPTH are still consumed and checksummed, only the write is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_hi <= '0;
      r_csum   <= '0;
      r_n      <= '0;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_ovf    <= 1'b0;
      r_ecsum  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= w_wv && w_in_range;
      if (w_wv && w_in_range) begin
        r_addr  <= r_idx[ADDR_W-1:0];
        r_wdata <= w_word;
      end
      if (w_wv) r_idx <= r_idx + CNT_W'(1);
      if (w_start) begin
        r_cnt_hi <= '0;
        r_csum   <= '0;
        r_n      <= '0;
        r_idx    <= '0;
        r_ovf    <= 1'b0;
        r_ecsum  <= 1'b0;
      end
      if (w_xfer && r_state == S_HDR0) r_cnt_hi <= in_data;
      if (w_xfer && r_state == S_HDR1) begin
        r_n   <= w_n_rx;
        r_ovf <= 32'(w_n_rx) > DEPTH;
      end
      if (w_xfer && r_state == S_DATA) r_csum <= r_csum ^ in_data;
      if (w_xfer && r_state == S_CSUM) r_ecsum <= in_data != r_csum;
    end
  end
  assign im_we    = r_we;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign err_ovf  = r_ovf;
  assign err_csum = r_ecsum;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frames into a DEPTH=256 and a DEPTH=4 loader sharing one byte stream
module tb_imem_loader;
  logic clk = 0, rst = 1, load_start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, im_we, cpu_hold, done, err_ovf, err_csum;
  logic [7:0] im_addr;
  logic [31:0] im_wdata;
  logic s_in_ready, s_im_we, s_cpu_hold, s_done, s_err_ovf, s_err_csum;
  logic [1:0] s_im_addr;
  logic [31:0] s_im_wdata;
  int checks = 0, errors = 0;
  int wa = 0, wb = 0;
  logic [7:0] la_a [8];
  logic [31:0] la_d [8];
  logic [1:0] lb_a [8];
  logic [31:0] lb_d [8];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err_ovf(err_ovf), .err_csum(err_csum));

  imem_loader #(.ADDR_W(2), .CNT_W(16)) dut_s (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .im_we(s_im_we), .im_addr(s_im_addr), .im_wdata(s_im_wdata),
    .cpu_hold(s_cpu_hold), .done(s_done), .err_ovf(s_err_ovf), .err_csum(s_err_csum));

  always @(negedge clk) begin
    if (im_we) begin
      if (wa < 8) begin la_a[wa] = im_addr; la_d[wa] = im_wdata; end
      wa++;
    end
    if (s_im_we) begin
      if (wb < 8) begin lb_a[wb] = s_im_addr; lb_d[wb] = s_im_wdata; end
      wb++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    int n;
    logic [4:0][31:0] w;
    logic [7:0] cs;
    int gaps;
    bit poke;
    bit e_cs;
  } vec_t;
  vec_t v [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    load_start = 1;
    @(negedge clk);
    load_start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gaps);
    int tmo = 0;
    if (gaps != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    in_data = b;
    in_valid = 1;
    while (!in_ready && tmo < 20) begin @(negedge clk); tmo++; end
    if (tmo == 20) begin errors++; checks++; $display("FAIL handshake timeout: in_ready 0 expected 1"); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " im_we"}, im_we, 0);
    chk({tag, " im_addr"}, im_addr, 0);
    chk({tag, " im_wdata"}, im_wdata, 0);
    chk({tag, " cpu_hold"}, cpu_hold, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err_ovf"}, err_ovf, 0);
    chk({tag, " err_csum"}, err_csum, 0);
  endtask

  task automatic run_frame(input vec_t t, input int id);
    logic [15:0] n16;
    logic [31:0] wd;
    int nb;
    n16 = 16'(t.n);
    nb = (t.n > 4) ? 4 : t.n;
    wa = 0;
    wb = 0;
    pulse_start();
    chk($sformatf("v%0d cpu_hold loading", id), cpu_hold, 1);
    chk($sformatf("v%0d done cleared", id), done, 0);
    chk($sformatf("v%0d errs cleared", id), {err_ovf, err_csum, s_err_ovf, s_err_csum}, 0);
    send(n16[15:8], t.gaps);
    send(n16[7:0], t.gaps);
    chk($sformatf("v%0d small err_ovf after CNT_LO", id), s_err_ovf, t.n > 4);
    for (int k = 0; k < t.n; k++) begin
      wd = t.w[k];
      for (int b = 0; b < 4; b++) begin
        send(wd[31-8*b -: 8], t.gaps);
        if (t.poke && k == 0 && b == 3) pulse_start();
      end
    end
    send(t.cs, t.gaps);
    chk($sformatf("v%0d done", id), {done, s_done}, 2'b11);
    chk($sformatf("v%0d cpu_hold released", id), {cpu_hold, s_cpu_hold}, 0);
    chk($sformatf("v%0d in_ready in DONE", id), in_ready, 0);
    chk($sformatf("v%0d err_csum", id), {err_csum, s_err_csum}, {t.e_cs, t.e_cs});
    chk($sformatf("v%0d err_ovf", id), {err_ovf, s_err_ovf}, {1'b0, t.n > 4});
    chk($sformatf("v%0d write count", id), wa, t.n);
    chk($sformatf("v%0d small write count", id), wb, nb);
    for (int k = 0; k < t.n && k < 8; k++)
      chk($sformatf("v%0d word %0d", id, k), {la_a[k], la_d[k]}, {8'(k), t.w[k]});
    for (int k = 0; k < nb; k++)
      chk($sformatf("v%0d small word %0d", id, k), {lb_a[k], lb_d[k]}, {2'(k), t.w[k]});
  endtask

  initial begin
    v[0] = '{2, {32'h0, 32'h0, 32'h0, 32'h0000000C, 32'h20080005}, 8'h21, 0, 0, 0};
    v[1] = '{2, {32'h0, 32'h0, 32'h0, 32'h0000000C, 32'h20080005}, 8'h00, 0, 0, 1};
    v[2] = '{2, {32'h0, 32'h0, 32'h0, 32'h0000000C, 32'h20080005}, 8'h2D, 0, 0, 1};
    v[3] = '{0, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 0, 0, 0};
    v[4] = '{5, {32'h000000FF, 32'hA0B0C0D0, 32'h01020304, 32'h55667788, 32'h11223344}, 8'h73, 0, 0, 0};
    v[5] = '{2, {32'h0, 32'h0, 32'h0, 32'h0000000C, 32'h20080005}, 8'h21, 1, 1, 0};
    v[6] = '{0, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 8'h5A, 0, 0, 1};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    in_data = 8'hAA;
    in_valid = 1;
    repeat (3) @(negedge clk);
    chk("idle in_ready", in_ready, 0);
    chk("idle no write", wa, 0);
    in_valid = 0;
    for (int i = 0; i < 7; i++) run_frame(v[i], i);
    pulse_start();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h00, 0); send(8'h00, 0);
    chk("pre-rst cpu_hold", cpu_hold, 1);
    rst = 1;
    @(negedge clk);
    check_reset_outputs("mid-rst");
    rst = 0;
    @(negedge clk);
    run_frame(v[0], 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
